// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit: state encoding,
// func3 codes, default ROB width and the IO region selector.
package load_store_unit_pkg;

  localparam int unsigned LSU_ROB_W = 4;
  localparam logic [1:0]  LSU_IO_HI = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_STORE = 2'd2
  } lsu_state_e;

  // Access size in bytes from func3[1:0]: byte, half, word.
  function automatic logic [2:0] lsu_byte_count(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-issue, RAM port and CDB signals of the load/store unit.
// Handshake: a request is offered whenever dest != 0; it is taken only when
// the unit is idle and not flushing, which it confirms with a one-cycle recv.
interface load_store_unit_if
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ROB_W = LSU_ROB_W
) ();
  logic             flush_input;
  logic             typ;
  logic [2:0]       op;
  logic [31:0]      rs1;
  logic [31:0]      rs2;
  logic [11:0]      offset;
  logic [ROB_W-1:0] dest;
  logic             io_buffer_full;
  logic [7:0]       mem_din;
  logic [31:0]      mem_a;
  logic [7:0]       mem_dout;
  logic             mem_wr;
  logic [ROB_W-1:0] rob_id;
  logic [31:0]      value;
  logic             recv;
  lsu_state_e       dbg_state;

  modport slave (
    input  flush_input, typ, op, rs1, rs2, offset, dest, io_buffer_full, mem_din,
    output mem_a, mem_dout, mem_wr, rob_id, value, recv, dbg_state
  );

  modport master (
    output flush_input, typ, op, rs1, rs2, offset, dest, io_buffer_full, mem_din,
    input  mem_a, mem_dout, mem_wr, rob_id, value, recv, dbg_state
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Load result extension: sign- or zero-extends the assembled little-endian
// bytes to 32 bits according to func3.
module lsu_load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] raw_i,
  output logic [31:0] value_o
);
  logic fill;

  always_comb begin
    fill    = 1'b0;
    value_o = raw_i;
    case (op_i[1:0])
      2'b00: begin
        fill    = ~op_i[2] & raw_i[7];
        value_o = {{24{fill}}, raw_i[7:0]};
      end
      2'b01: begin
        fill    = ~op_i[2] & raw_i[15];
        value_o = {{16{fill}}, raw_i[15:0]};
      end
      default: value_o = raw_i;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Byte-serial load/store unit: takes one request from the memory reservation
// station, runs it on the 8-bit RAM port and reports on the MEM CDB lane.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned ROB_W = LSU_ROB_W,
  parameter logic [1:0]  IO_HI = LSU_IO_HI
) (
  input logic              clk_in,
  input logic              rst_in,
  load_store_unit_if.slave lsu
);
  lsu_state_e       state_q, state_d;
  // LOAD: index of the coming edge since accept. STORE: next byte to write.
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [ROB_W-1:0] dest_q, dest_d;
  logic [31:0]      rs2_q, rs2_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      buf_q, buf_d;
  logic             flushed_q, flushed_d;
  logic [31:0]      mem_a_q, mem_a_d;
  logic [7:0]       mem_dout_q, mem_dout_d;
  logic             mem_wr_q, mem_wr_d;
  logic [ROB_W-1:0] rob_id_q, rob_id_d;
  logic [31:0]      value_q, value_d;
  logic             recv_q, recv_d;

  logic [2:0]  n_bytes;
  logic [31:0] acc_addr;
  logic [31:0] cur_addr;
  logic [31:0] raw;
  logic [31:0] ext_value;
  logic [7:0]  st_byte;
  logic        io_stall;

  lsu_load_extend u_ext (
    .op_i    (op_q),
    .raw_i   (raw),
    .value_o (ext_value)
  );

  always_comb begin
    n_bytes  = lsu_byte_count(op_q);
    acc_addr = lsu.rs1 + {{20{lsu.offset[11]}}, lsu.offset};
    cur_addr = addr_q + {29'd0, cnt_q};
    io_stall = (addr_q[17:16] == IO_HI) && lsu.io_buffer_full;
    // The last byte of a load is used straight from mem_din on the final edge.
    raw = buf_q;
    case (op_q[1:0])
      2'b00:   raw[7:0]   = lsu.mem_din;
      2'b01:   raw[15:8]  = lsu.mem_din;
      default: raw[31:24] = lsu.mem_din;
    endcase
    case (cnt_q[1:0])
      2'd0:    st_byte = rs2_q[7:0];
      2'd1:    st_byte = rs2_q[15:8];
      2'd2:    st_byte = rs2_q[23:16];
      default: st_byte = rs2_q[31:24];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    dest_d     = dest_q;
    rs2_d      = rs2_q;
    addr_d     = addr_q;
    buf_d      = buf_q;
    flushed_d  = flushed_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = 1'b0;
    rob_id_d   = '0;
    value_d    = '0;
    recv_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if ((lsu.dest != '0) && !lsu.flush_input) begin
          op_d      = lsu.op;
          dest_d    = lsu.dest;
          rs2_d     = lsu.rs2;
          addr_d    = acc_addr;
          buf_d     = '0;
          flushed_d = 1'b0;
          recv_d    = 1'b1;
          mem_a_d   = acc_addr;
          if (lsu.typ) begin
            state_d = ST_STORE;
            if ((acc_addr[17:16] == IO_HI) && lsu.io_buffer_full) begin
              cnt_d = 3'd0;
            end else begin
              mem_dout_d = lsu.rs2[7:0];
              mem_wr_d   = 1'b1;
              cnt_d      = 3'd1;
            end
          end else begin
            state_d = ST_LOAD;
            cnt_d   = 3'd1;
          end
        end
      end

      ST_LOAD: begin
        if (lsu.flush_input) begin
          state_d = ST_IDLE;
          mem_a_d = '0;
        end else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q < n_bytes) mem_a_d = cur_addr;
          case (cnt_q)
            3'd2:    buf_d[7:0]   = lsu.mem_din;
            3'd3:    buf_d[15:8]  = lsu.mem_din;
            3'd4:    buf_d[23:16] = lsu.mem_din;
            3'd5:    buf_d[31:24] = lsu.mem_din;
            default: ;
          endcase
          if (cnt_q == n_bytes + 3'd1) begin
            state_d  = ST_IDLE;
            mem_a_d  = '0;
            rob_id_d = dest_q;
            value_d  = ext_value;
          end
        end
      end

      ST_STORE: begin
        // A flushed store still finishes its bytes; only the CDB report is dropped.
        if (lsu.flush_input) flushed_d = 1'b1;
        if (cnt_q < n_bytes) begin
          mem_a_d = cur_addr;
          if (!io_stall) begin
            mem_dout_d = st_byte;
            mem_wr_d   = 1'b1;
            cnt_d      = cnt_q + 3'd1;
          end
        end else begin
          state_d    = ST_IDLE;
          mem_a_d    = '0;
          mem_dout_d = '0;
          if (!(flushed_q || lsu.flush_input)) rob_id_d = dest_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      dest_q     <= '0;
      rs2_q      <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
      flushed_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      rob_id_q   <= '0;
      value_q    <= '0;
      recv_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      dest_q     <= dest_d;
      rs2_q      <= rs2_d;
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      flushed_q  <= flushed_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      rob_id_q   <= rob_id_d;
      value_q    <= value_d;
      recv_q     <= recv_d;
    end
  end

  assign lsu.mem_a     = mem_a_q;
  assign lsu.mem_dout  = mem_dout_q;
  assign lsu.mem_wr    = mem_wr_q;
  assign lsu.rob_id    = rob_id_q;
  assign lsu.value     = value_q;
  assign lsu.recv      = recv_q;
  assign lsu.dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a byte RAM model with one-cycle read
// latency, hand-computed expectations and immediate-assertion checks.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk_in;
  logic rst_in;
  int   n_tests;
  int   n_fail;

  load_store_unit_if bus ();

  load_store_unit u_dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .lsu    (bus)
  );

  // Clock and RAM model
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return 8'h00;
  endfunction

  always @(posedge clk_in) begin
    if (bus.mem_wr) ram[bus.mem_a] = bus.mem_dout;
    bus.mem_din <= ram_rd(bus.mem_a);
  end

  // Driver and checker tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_req();
    bus.typ    = 1'b0;
    bus.op     = 3'd0;
    bus.rs1    = 32'd0;
    bus.rs2    = 32'd0;
    bus.offset = 12'd0;
    bus.dest   = 4'd0;
  endtask

  // Presents a request for one edge (E0) and checks that it was taken.
  task automatic issue(input logic t, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] d, input logic [11:0] off, input logic [3:0] id);
    bus.typ    = t;
    bus.op     = o;
    bus.rs1    = a;
    bus.rs2    = d;
    bus.offset = off;
    bus.dest   = id;
    tick();
    check("recv_pulse", 32'(bus.recv), 32'd1);
    clear_req();
  endtask

  // From just after E0: CDB must stay quiet until edge E<lat>, pulse once, then clear.
  task automatic expect_cdb(input string tag, input int lat, input logic [3:0] id,
                            input logic [31:0] val);
    for (int k = 1; k < lat; k++) begin
      tick();
      check({tag, "_quiet"}, 32'(bus.rob_id), 32'd0);
    end
    tick();
    check({tag, "_id"}, 32'(bus.rob_id), 32'(id));
    check({tag, "_val"}, bus.value, val);
    tick();
    check({tag, "_clr"}, 32'(bus.rob_id), 32'd0);
  endtask

  // Counts CDB pulses over a window of edges.
  task automatic count_cdb(input int edges, output int cnt);
    cnt = 0;
    for (int k = 0; k < edges; k++) begin
      tick();
      if (bus.rob_id != 4'd0) cnt++;
    end
  endtask

  int n_recv;
  int n_cdb;
  logic [31:0] last_val;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_in  = 1'b0;
    bus.flush_input    = 1'b0;
    bus.io_buffer_full = 1'b0;
    clear_req();
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56;
    ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h20]  = 8'h80;
    ram[32'h500] = 8'h34; ram[32'h501] = 8'h92;

    // Reset
    #1 rst_in = 1'b1;
    #1;
    check("rst_mem_a", bus.mem_a, 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
    check("rst_recv", 32'(bus.recv), 32'd0);
    check("rst_rob_id", 32'(bus.rob_id), 32'd0);
    check("rst_value", bus.value, 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    tick();
    tick();
    rst_in = 1'b0;
    tick();

    // LW with negative offset: addresses step 0x100..0x103, result at E5
    issue(1'b0, F3_LW, 32'h104, 32'd0, 12'hFFC, 4'd5);
    check("lw_a0", bus.mem_a, 32'h100);
    check("lw_wr0", 32'(bus.mem_wr), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("lw_recv_drop", 32'(bus.recv), 32'd0);
      check("lw_addr", bus.mem_a, 32'h100 + 32'(i));
    end
    tick();
    check("lw_e4_quiet", 32'(bus.rob_id), 32'd0);
    tick();
    check("lw_id", 32'(bus.rob_id), 32'd5);
    check("lw_val", bus.value, 32'h12345678);
    check("lw_a_zero", bus.mem_a, 32'd0);
    tick();
    check("lw_clr_id", 32'(bus.rob_id), 32'd0);
    check("lw_clr_val", bus.value, 32'd0);

    // LB sign-extends, LBU zero-extends
    issue(1'b0, F3_LB, 32'h20, 32'd0, 12'd0, 4'd3);
    expect_cdb("lb", 2, 4'd3, 32'hFFFFFF80);
    issue(1'b0, F3_LBU, 32'h20, 32'd0, 12'd0, 4'd4);
    expect_cdb("lbu", 2, 4'd4, 32'h00000080);

    // LH / LHU, result at E3
    issue(1'b0, F3_LH, 32'h4FF, 32'd0, 12'd1, 4'd1);
    expect_cdb("lh", 3, 4'd1, 32'hFFFF9234);
    issue(1'b0, F3_LHU, 32'h500, 32'd0, 12'd0, 4'd2);
    expect_cdb("lhu", 3, 4'd2, 32'h00009234);

    // SH unaligned: DD@0x201, CC@0x202, then CDB with value 0
    issue(1'b1, F3_SH, 32'h201, 32'hAABBCCDD, 12'd0, 4'd7);
    check("sh_wr0", 32'(bus.mem_wr), 32'd1);
    check("sh_a0", bus.mem_a, 32'h201);
    check("sh_d0", 32'(bus.mem_dout), 32'hDD);
    tick();
    check("sh_wr1", 32'(bus.mem_wr), 32'd1);
    check("sh_a1", bus.mem_a, 32'h202);
    check("sh_d1", 32'(bus.mem_dout), 32'hCC);
    tick();
    check("sh_wr_off", 32'(bus.mem_wr), 32'd0);
    check("sh_id", 32'(bus.rob_id), 32'd7);
    check("sh_val", bus.value, 32'd0);
    tick();
    check("sh_clr", 32'(bus.rob_id), 32'd0);
    check("sh_ram", {16'd0, ram_rd(32'h202), ram_rd(32'h201)}, 32'h0000CCDD);
    check("sh_ram_untouched", 32'(ram_rd(32'h203)), 32'd0);

    // IO store stalled by a full buffer for three edges
    bus.io_buffer_full = 1'b1;
    issue(1'b1, F3_SB, 32'h30000, 32'h0000005A, 12'd0, 4'd2);
    check("io_stall0", 32'(bus.mem_wr), 32'd0);
    tick();
    check("io_stall1", 32'(bus.mem_wr), 32'd0);
    tick();
    check("io_stall2", 32'(bus.mem_wr), 32'd0);
    bus.io_buffer_full = 1'b0;
    tick();
    check("io_wr", 32'(bus.mem_wr), 32'd1);
    check("io_a", bus.mem_a, 32'h30000);
    check("io_d", 32'(bus.mem_dout), 32'h5A);
    tick();
    check("io_wr_off", 32'(bus.mem_wr), 32'd0);
    check("io_id", 32'(bus.rob_id), 32'd2);
    tick();
    check("io_clr", 32'(bus.rob_id), 32'd0);
    check("io_ram", 32'(ram_rd(32'h30000)), 32'h5A);

    // LW flushed at E2: abort, no CDB
    issue(1'b0, F3_LW, 32'h100, 32'd0, 12'd0, 4'd6);
    tick();
    bus.flush_input = 1'b1;
    tick();
    bus.flush_input = 1'b0;
    check("lwf_a", bus.mem_a, 32'd0);
    check("lwf_wr", 32'(bus.mem_wr), 32'd0);
    tick();
    check("lwf_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    count_cdb(6, n_cdb);
    check("lwf_no_cdb", 32'(n_cdb), 32'd0);

    // SW flushed at E1: all four bytes land, no CDB
    issue(1'b1, F3_SW, 32'h400, 32'h11223344, 12'd0, 4'd8);
    bus.flush_input = 1'b1;
    tick();
    bus.flush_input = 1'b0;
    count_cdb(7, n_cdb);
    check("swf_no_cdb", 32'(n_cdb), 32'd0);
    check("swf_ram", {ram_rd(32'h403), ram_rd(32'h402), ram_rd(32'h401), ram_rd(32'h400)},
          32'h11223344);
    check("swf_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Next request after flushes proceeds normally
    issue(1'b0, F3_LB, 32'h20, 32'd0, 12'd0, 4'd9);
    expect_cdb("post_flush", 2, 4'd9, 32'hFFFFFF80);

    // Request held for two edges: one accept, one execution
    n_recv = 0;
    n_cdb  = 0;
    last_val = 32'd0;
    bus.typ = 1'b0; bus.op = F3_LW; bus.rs1 = 32'h100; bus.offset = 12'd0; bus.dest = 4'd11;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 1) clear_req();
      if (bus.recv) n_recv++;
      if (bus.rob_id != 4'd0) begin
        n_cdb++;
        last_val = bus.value;
      end
    end
    check("hold_recv_cnt", 32'(n_recv), 32'd1);
    check("hold_cdb_cnt", 32'(n_cdb), 32'd1);
    check("hold_val", last_val, 32'h12345678);

    // Async reset in the middle of a LW
    issue(1'b0, F3_LW, 32'h100, 32'd0, 12'd0, 4'd12);
    tick();
    check("arst_pre_a", bus.mem_a, 32'h101);
    #2 rst_in = 1'b1;
    #1;
    check("arst_a", bus.mem_a, 32'd0);
    check("arst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("arst_recv", 32'(bus.recv), 32'd0);
    check("arst_rob", 32'(bus.rob_id), 32'd0);
    check("arst_val", bus.value, 32'd0);
    tick();
    rst_in = 1'b0;
    count_cdb(6, n_cdb);
    check("arst_no_cdb", 32'(n_cdb), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
